// File: rtl/tty_pkg.sv
// rtl/tty_pkg.sv - shared ASCII codes, FSM states and byte classification for the tty text writer
package tty_pkg;

    localparam logic [7:0] CHR_SPACE    = 8'h20;
    localparam logic [7:0] CHR_LF       = 8'h0A;
    localparam logic [7:0] CHR_CR       = 8'h0D;
    localparam logic [7:0] CHR_BS       = 8'h08;
    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } tty_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHR_PRINT_LO) && (b <= CHR_PRINT_HI);
    endfunction

endpackage

// File: rtl/tty_text_writer_if.sv
// rtl/tty_text_writer_if.sv - byte-stream input and text-buffer write port of the tty text writer
interface tty_text_writer_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] vga_waddr;
    logic [7:0]        vga_wdata;
    logic              vga_wr_en;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  vga_waddr,
        input  vga_wdata,
        input  vga_wr_en
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output vga_waddr,
        output vga_wdata,
        output vga_wr_en
    );
endinterface

// File: rtl/tty_cursor.sv
// rtl/tty_cursor.sv - cursor column/row tracking with a ring line base (no multiplier)
module tty_cursor #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 14
) (
    input  logic              clk48,
    input  logic              rst,
    input  logic              inc,
    input  logic              cr,
    input  logic              bs,
    input  logic              newline,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] line_base,
    output logic              at_last_col
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              advance;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        advance = 1'b0;
        if (newline) begin
            col_d   = '0;
            advance = 1'b1;
        end else if (inc) begin
            if (col_q == COL_LAST) begin
                col_d   = '0;
                advance = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (cr) begin
            col_d = '0;
        end else if (bs && (col_q != '0)) begin
            col_d = col_q - 1'b1;
        end
        // Line base tracks the row by repeated addition so the ring wrap stays cheap.
        if (advance) begin
            if (row_q == ROW_LAST) begin
                row_d  = '0;
                base_d = '0;
            end else begin
                row_d  = row_q + 1'b1;
                base_d = base_q + COLS_A;
            end
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

    assign addr        = base_q + ADDR_W'(col_q);
    assign line_base   = base_q;
    assign at_last_col = (col_q == COL_LAST);

endmodule

// File: rtl/tty_text_writer.sv
// rtl/tty_text_writer.sv - renders a UART byte stream into a write-only VGA text buffer
module tty_text_writer
    import tty_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 14
) (
    input  logic             clk48,
    input  logic             rst,
    tty_text_writer_if.slave bus
);
    localparam int CNT_W = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1;
    localparam logic [CNT_W-1:0] CNT_ALL_LAST = CNT_W'(COLS * ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_ROW_LAST = CNT_W'(COLS - 1);

    tty_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              cur_inc, cur_cr, cur_bs, cur_nl;
    logic [ADDR_W-1:0] cur_addr, cur_line_base;
    logic              cur_at_last_col;

    tty_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk48       (clk48),
        .rst         (rst),
        .inc         (cur_inc),
        .cr          (cur_cr),
        .bs          (cur_bs),
        .newline     (cur_nl),
        .addr        (cur_addr),
        .line_base   (cur_line_base),
        .at_last_col (cur_at_last_col)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        wr_en_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cur_inc = 1'b0;
        cur_cr  = 1'b0;
        cur_bs  = 1'b0;
        cur_nl  = 1'b0;
        case (state_q)
            CLEAR_ALL: begin
                wr_en_d = 1'b1;
                waddr_d = ADDR_W'(cnt_q);
                wdata_d = CHR_SPACE;
                if (cnt_q == CNT_ALL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                rdy_d = 1'b1;
                if (bus.in_valid && rdy_q) begin
                    if (is_printable(bus.in_data)) begin
                        wr_en_d = 1'b1;
                        waddr_d = cur_addr;
                        wdata_d = bus.in_data;
                        cur_inc = 1'b1;
                        // The wrapping write and the entry into the row clear share this edge.
                        if (cur_at_last_col) begin
                            state_d = CLEAR_ROW;
                            rdy_d   = 1'b0;
                            cnt_d   = '0;
                        end
                    end else if (bus.in_data == CHR_LF) begin
                        cur_nl  = 1'b1;
                        state_d = CLEAR_ROW;
                        rdy_d   = 1'b0;
                        cnt_d   = '0;
                    end else if (bus.in_data == CHR_CR) begin
                        cur_cr = 1'b1;
                    end else if (bus.in_data == CHR_BS) begin
                        cur_bs = 1'b1;
                    end
                end
            end
            CLEAR_ROW: begin
                // Cursor already points at the new row, so line_base is the row to blank.
                wr_en_d = 1'b1;
                waddr_d = cur_line_base + ADDR_W'(cnt_q);
                wdata_d = CHR_SPACE;
                if (cnt_q == CNT_ROW_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR_ALL;
                cnt_d   = '0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q <= CLEAR_ALL;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.vga_wr_en = wr_en_q;
    assign bus.vga_waddr = waddr_q;
    assign bus.vga_wdata = wdata_q;

endmodule

// File: tb/tb_tty_text_writer.sv
// tb/tb_tty_text_writer.sv - scoreboard bench for tty_text_writer
module tb_tty_text_writer;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 14;

    logic clk48 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk48 = ~clk48;

    tty_text_writer_if #(.ADDR_W(ADDR_W)) bus ();

    tty_text_writer #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk48 (clk48),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              rdy;
        logic              contig;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   cyc         = 0;
    int   last_wr_cyc = -10;
    int   mcol        = 0;
    int   mrow        = 0;

    initial forever begin
        @(posedge clk48);
        cyc++;
    end

    // Monitor: every write strobe must match the head of the expected queue.
    initial forever begin
        exp_t e;
        @(negedge clk48);
        if (bus.vga_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h, nothing expected", bus.vga_waddr, bus.vga_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.vga_waddr !== e.addr || bus.vga_wdata !== e.data || bus.in_ready !== e.rdy) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%h rdy=%b expected addr=%0d data=%h rdy=%b",
                             bus.vga_waddr, bus.vga_wdata, bus.in_ready, e.addr, e.data, e.rdy);
                end
                if (e.contig) begin
                    checks++;
                    if (last_wr_cyc != cyc - 1) begin
                        failures++;
                        $display("FAIL write_gap addr=%0d got gap=%0d expected gap=1", e.addr, cyc - last_wr_cyc);
                    end
                end
            end
            last_wr_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d, input logic r, input logic c);
        exp_t e;
        e.addr   = ADDR_W'(a);
        e.data   = d;
        e.rdy    = r;
        e.contig = c;
        exp_q.push_back(e);
    endtask

    task automatic push_clear_row();
        for (int i = 0; i < COLS; i++) push(mrow * COLS + i, 8'h20, i == COLS - 1, i > 0);
    endtask

    task automatic push_clear_all();
        for (int i = 0; i < COLS * ROWS; i++) push(i, 8'h20, i == COLS * ROWS - 1, i > 0);
        mcol = 0;
        mrow = 0;
    endtask

    task automatic advance_row();
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_clear_row();
    endtask

    task automatic model(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(mrow * COLS + mcol, b, mcol != COLS - 1, 1'b0);
            mcol++;
            if (mcol == COLS) advance_row();
        end else if (b == 8'h0A) begin
            advance_row();
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h08 && mcol > 0) begin
            mcol--;
        end
    endtask

    // Called and returning just after a rising edge; random idle gaps model a bursty source.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk48);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 6000 && !done; n++) begin
            @(negedge clk48);
            rdy = bus.in_ready;
            @(posedge clk48);
            #1;
            if (rdy) done = 1'b1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done) begin
            model(b);
        end else begin
            failures++;
            $display("FAIL handshake_timeout byte=%h got no acceptance expected acceptance", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 6000 && exp_q.size() != 0; n++) begin
            @(posedge clk48);
            #1;
        end
        repeat (4) begin
            @(posedge clk48);
            #1;
        end
        chk({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst          = 1'b1;
        repeat (3) begin
            @(posedge clk48);
            #1;
        end
        @(negedge clk48);
        chk("reset_wr_en", int'(bus.vga_wr_en), 0);
        chk("reset_waddr", int'(bus.vga_waddr), 0);
        chk("reset_wdata", int'(bus.vga_wdata), 0);
        chk("reset_in_ready", int'(bus.in_ready), 0);
        push_clear_all();
        @(posedge clk48);
        #1;
        rst = 1'b0;
        @(posedge clk48);
        @(negedge clk48);
        chk("first_clear_wr_en", int'(bus.vga_wr_en), 1);
        chk("first_clear_addr", int'(bus.vga_waddr), 0);
        wait_drain("clear_all");
        chk("ready_after_clear", int'(bus.in_ready), 1);

        send_str("AB");
        wait_drain("ab");

        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte(8'h30 + 8'(i % 64));
        send_str("Z");
        wait_drain("row_wrap");

        for (int i = 0; i < 28; i++) send_byte(8'h0A);
        send_str("Q");
        send_byte(8'h0A);
        wait_drain("screen_wrap");

        send_byte(8'h08);
        send_str("Xab");
        send_byte(8'h08);
        send_str("c");
        send_byte(8'h0D);
        send_str("k");
        send_byte(8'h07);
        send_byte(8'h7F);
        send_byte(8'hC3);
        send_str("z");
        wait_drain("controls");

        send_byte(8'h0A);
        fork
            send_byte(8'h4D);
            begin
                repeat (20) begin
                    @(posedge clk48);
                    #1;
                end
                rst = 1'b1;
                @(posedge clk48);
                #1;
                exp_q.delete();
                push_clear_all();
                @(negedge clk48);
                chk("mid_row_reset_wr_en", int'(bus.vga_wr_en), 0);
                chk("mid_row_reset_in_ready", int'(bus.in_ready), 0);
                @(posedge clk48);
                #1;
                rst = 1'b0;
            end
        join
        send_str("ok");
        wait_drain("reset_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
